// File: rtl/airi5c_mem_arbiter.sv
// -----------------------------------------------------------------------------
// airi5c_mem_arbiter
//
// Shares one single-port 32-bit SRAM macro between three requesters: the core
// instruction AHB-lite port (imem), the core data AHB-lite port (dmem) and the
// management Wishbone slave (wb).
//
// Each AHB port has an address-phase capture register. A captured transfer
// becomes eligible for the SRAM one cycle after capture, so a write completes
// after one wait state and a read after two. Wishbone accesses get a single
// ack one cycle after their SRAM grant. The wb port always wins. Between the
// AHB ports dmem beats imem, unless AIRI5C_MEM_ARB_RR_EN is defined, in which
// case imem and dmem alternate via a 1-bit pointer.
//
// Optional feature macro: AIRI5C_MEM_ARB_RR_EN (round-robin imem/dmem).
//
// Ports:
//   clk, nreset             clock, asynchronous active-low reset
//   imem_* / dmem_*         AHB-lite slave ports (haddr, hwrite, hsize, htrans,
//                           hwdata in; hrdata, hready, hresp out)
//   wbs_*                   Wishbone slave (cyc, stb, we, sel, adr, dat in;
//                           ack, dat out)
//   sram_*                  SRAM macro port (en, we, wmask, addr, wdata out;
//                           rdata in, valid the cycle after a read strobe)
// -----------------------------------------------------------------------------
module airi5c_mem_arbiter #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  nreset,

    input  logic [31:0]           imem_haddr,
    input  logic                  imem_hwrite,
    input  logic [2:0]            imem_hsize,
    input  logic [1:0]            imem_htrans,
    input  logic [31:0]           imem_hwdata,
    output logic [31:0]           imem_hrdata,
    output logic                  imem_hready,
    output logic                  imem_hresp,

    input  logic [31:0]           dmem_haddr,
    input  logic                  dmem_hwrite,
    input  logic [2:0]            dmem_hsize,
    input  logic [1:0]            dmem_htrans,
    input  logic [31:0]           dmem_hwdata,
    output logic [31:0]           dmem_hrdata,
    output logic                  dmem_hready,
    output logic                  dmem_hresp,

    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,

    output logic                  sram_en,
    output logic                  sram_we,
    output logic [3:0]            sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    localparam int AW = ADDR_WIDTH;

    // Byte-lane write mask for an AHB transfer; sizes above word act as word.
    function automatic logic [3:0] ahb_byte_mask(input logic [2:0] size,
                                                 input logic [1:0] lsb);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0001 << lsb;
            3'd1:    mask = lsb[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // imem capture state
    logic          i_pend_r;
    logic          i_elig_r;
    logic          i_rbusy_r;
    logic [AW+1:0] i_addr_r;
    logic          i_write_r;
    logic [2:0]    i_size_r;
    logic          i_ready_s;
    logic          i_capture_s;
    logic          i_req_s;
    logic          i_gnt_s;

    // dmem capture state
    logic          d_pend_r;
    logic          d_elig_r;
    logic          d_rbusy_r;
    logic [AW+1:0] d_addr_r;
    logic          d_write_r;
    logic [2:0]    d_size_r;
    logic          d_ready_s;
    logic          d_capture_s;
    logic          d_req_s;
    logic          d_gnt_s;

    // wishbone and arbitration state
    logic          run_r;
    logic          ack_r;
    logic          wb_gnt_s;
    logic          dmem_first_s;

    // SRAM port drive and hold registers
    logic          sram_en_s;
    logic          sram_we_s;
    logic [3:0]    sram_wmask_s;
    logic [AW-1:0] sram_addr_s;
    logic [31:0]   sram_wdata_s;
    logic          last_we_r;
    logic [3:0]    last_wmask_r;
    logic [AW-1:0] last_addr_r;
    logic [31:0]   last_wdata_r;

    // Address bits above the SRAM size are deliberately ignored (wrap).
    logic unused_s;
    assign unused_s = ^{imem_haddr[31:AW+2], dmem_haddr[31:AW+2],
                        imem_htrans[0], dmem_htrans[0],
                        wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

    // A write completes in its grant cycle, a read in the cycle after grant.
    assign i_ready_s   = ~i_pend_r | (i_gnt_s & i_write_r) | i_rbusy_r;
    assign d_ready_s   = ~d_pend_r | (d_gnt_s & d_write_r) | d_rbusy_r;
    assign i_capture_s = i_ready_s & imem_htrans[1];
    assign d_capture_s = d_ready_s & dmem_htrans[1];
    assign i_req_s     = i_pend_r & i_elig_r;
    assign d_req_s     = d_pend_r & d_elig_r;

    // run_r keeps wb off the SRAM until the first edge after reset release.
    assign wb_gnt_s    = run_r & wbs_cyc_i & wbs_stb_i & ~ack_r;

`ifdef AIRI5C_MEM_ARB_RR_EN
    logic prio_dmem_r;

    assign dmem_first_s = prio_dmem_r;

    // Round-robin pointer: favour the AHB port that was not granted last.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prio_dmem_r <= 1'b1;
        end else if (d_gnt_s) begin
            prio_dmem_r <= 1'b0;
        end else if (i_gnt_s) begin
            prio_dmem_r <= 1'b1;
        end else begin
            prio_dmem_r <= prio_dmem_r;
        end
    end
`else
    assign dmem_first_s = 1'b1;
`endif

    // Grant selection: wb absolute priority, then dmem/imem order.
    always_comb begin
        d_gnt_s = 1'b0;
        i_gnt_s = 1'b0;
        if (wb_gnt_s) begin
            d_gnt_s = 1'b0;
            i_gnt_s = 1'b0;
        end else if (d_req_s && (dmem_first_s || !i_req_s)) begin
            d_gnt_s = 1'b1;
        end else if (i_req_s) begin
            i_gnt_s = 1'b1;
        end else begin
            d_gnt_s = 1'b0;
            i_gnt_s = 1'b0;
        end
    end

    // imem address-phase capture and pending/eligible tracking.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            i_pend_r  <= 1'b0;
            i_elig_r  <= 1'b0;
            i_rbusy_r <= 1'b0;
            i_addr_r  <= '0;
            i_write_r <= 1'b0;
            i_size_r  <= 3'd0;
        end else begin
            i_rbusy_r <= i_gnt_s & ~i_write_r;
            if (i_capture_s) begin
                i_pend_r  <= 1'b1;
                i_elig_r  <= 1'b0;
                i_addr_r  <= imem_haddr[AW+1:0];
                i_write_r <= imem_hwrite;
                i_size_r  <= imem_hsize;
            end else if ((i_gnt_s & i_write_r) | i_rbusy_r) begin
                i_pend_r <= 1'b0;
                i_elig_r <= 1'b0;
            end else if (i_gnt_s) begin
                i_elig_r <= 1'b0;
            end else begin
                i_elig_r <= i_pend_r;
            end
        end
    end

    // dmem address-phase capture and pending/eligible tracking.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            d_pend_r  <= 1'b0;
            d_elig_r  <= 1'b0;
            d_rbusy_r <= 1'b0;
            d_addr_r  <= '0;
            d_write_r <= 1'b0;
            d_size_r  <= 3'd0;
        end else begin
            d_rbusy_r <= d_gnt_s & ~d_write_r;
            if (d_capture_s) begin
                d_pend_r  <= 1'b1;
                d_elig_r  <= 1'b0;
                d_addr_r  <= dmem_haddr[AW+1:0];
                d_write_r <= dmem_hwrite;
                d_size_r  <= dmem_hsize;
            end else if ((d_gnt_s & d_write_r) | d_rbusy_r) begin
                d_pend_r <= 1'b0;
                d_elig_r <= 1'b0;
            end else if (d_gnt_s) begin
                d_elig_r <= 1'b0;
            end else begin
                d_elig_r <= d_pend_r;
            end
        end
    end

    // Wishbone single-cycle ack and post-reset run enable.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ack_r <= 1'b0;
            run_r <= 1'b0;
        end else begin
            ack_r <= wb_gnt_s;
            run_r <= 1'b1;
        end
    end

    // SRAM port mux; when nobody is granted the previous values are held.
    always_comb begin
        sram_en_s    = 1'b0;
        sram_we_s    = last_we_r;
        sram_wmask_s = last_wmask_r;
        sram_addr_s  = last_addr_r;
        sram_wdata_s = last_wdata_r;
        if (wb_gnt_s) begin
            sram_en_s    = 1'b1;
            sram_we_s    = wbs_we_i;
            sram_wmask_s = wbs_sel_i;
            sram_addr_s  = wbs_adr_i[AW+1:2];
            sram_wdata_s = wbs_dat_i;
        end else if (d_gnt_s) begin
            sram_en_s    = 1'b1;
            sram_we_s    = d_write_r;
            sram_wmask_s = ahb_byte_mask(d_size_r, d_addr_r[1:0]);
            sram_addr_s  = d_addr_r[AW+1:2];
            sram_wdata_s = dmem_hwdata;
        end else if (i_gnt_s) begin
            sram_en_s    = 1'b1;
            sram_we_s    = i_write_r;
            sram_wmask_s = ahb_byte_mask(i_size_r, i_addr_r[1:0]);
            sram_addr_s  = i_addr_r[AW+1:2];
            sram_wdata_s = imem_hwdata;
        end else begin
            sram_en_s = 1'b0;
        end
    end

    // Remember the last driven SRAM controls for the idle hold.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            last_we_r    <= 1'b0;
            last_wmask_r <= 4'b0000;
            last_addr_r  <= '0;
            last_wdata_r <= 32'd0;
        end else begin
            last_we_r    <= sram_we_s;
            last_wmask_r <= sram_wmask_s;
            last_addr_r  <= sram_addr_s;
            last_wdata_r <= sram_wdata_s;
        end
    end

    assign sram_en     = sram_en_s;
    assign sram_we     = sram_we_s;
    assign sram_wmask  = sram_wmask_s;
    assign sram_addr   = sram_addr_s;
    assign sram_wdata  = sram_wdata_s;

    assign imem_hready = i_ready_s;
    assign dmem_hready = d_ready_s;
    assign imem_hresp  = 1'b0;
    assign dmem_hresp  = 1'b0;
    assign imem_hrdata = sram_rdata;
    assign dmem_hrdata = sram_rdata;

    assign wbs_ack_o   = ack_r;
    assign wbs_dat_o   = sram_rdata;

endmodule

// File: tb/tb_airi5c_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_airi5c_mem_arbiter
//
// Directed bench for airi5c_mem_arbiter with a behavioural SRAM and a
// reference memory image. Expected values are queued when a transfer is
// issued and popped when the DUT completes it.
// -----------------------------------------------------------------------------
module tb_airi5c_mem_arbiter;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          nreset;
    logic [31:0]   imem_haddr, dmem_haddr;
    logic          imem_hwrite, dmem_hwrite;
    logic [2:0]    imem_hsize, dmem_hsize;
    logic [1:0]    imem_htrans, dmem_htrans;
    logic [31:0]   imem_hwdata, dmem_hwdata;
    logic [31:0]   imem_hrdata, dmem_hrdata;
    logic          imem_hready, dmem_hready;
    logic          imem_hresp, dmem_hresp;
    logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i, wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          sram_en, sram_we;
    logic [3:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [31:0]   sb_q[$];
    logic [31:0]   ref_mem [0:(1<<AW)-1];
    logic [31:0]   sram_mem [0:(1<<AW)-1];

    airi5c_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .nreset(nreset),
        .imem_haddr(imem_haddr), .imem_hwrite(imem_hwrite), .imem_hsize(imem_hsize),
        .imem_htrans(imem_htrans), .imem_hwdata(imem_hwdata), .imem_hrdata(imem_hrdata),
        .imem_hready(imem_hready), .imem_hresp(imem_hresp),
        .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize),
        .dmem_htrans(dmem_htrans), .dmem_hwdata(dmem_hwdata), .dmem_hrdata(dmem_hrdata),
        .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .sram_en(sram_en), .sram_we(sram_we), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: read data appears the cycle after strobe.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
        chk(tag, obs, exp);
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // One dmem transfer: capture, then wait (bounded) for hready.
    task automatic dmem_xfer(input string tag, input logic wr, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int exp_waits, input logic [3:0] exp_mask);
        int          waits;
        logic        done;
        logic [AW-1:0] widx;
        widx = a[AW+1:2];
        cyc_start();
        dmem_haddr = a; dmem_hwrite = wr; dmem_hsize = sz; dmem_htrans = 2'b10;
        if (wr) sb_q.push_back({28'd0, exp_mask});
        else    sb_q.push_back(ref_mem[widx]);
        settle();
        chk({tag, "_cap_rdy"}, {31'd0, dmem_hready}, 32'd1);
        cyc_start();
        dmem_htrans = 2'b00; dmem_hwdata = wd;
        settle();
        waits = 0; done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!done) begin
                if (k > 0) begin cyc_start(); settle(); end
                if (dmem_hready) begin
                    done = 1'b1;
                    if (wr) begin
                        sb_chk({tag, "_wmask"}, {28'd0, sram_wmask});
                        chk({tag, "_we"}, {31'd0, sram_en & sram_we}, 32'd1);
                        chk({tag, "_addr"}, {21'd0, sram_addr}, {21'd0, widx});
                        chk({tag, "_wdata"}, sram_wdata, wd);
                    end else begin
                        sb_chk({tag, "_rdata"}, dmem_hrdata);
                    end
                end else begin
                    waits++;
                end
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_waits"}, waits, exp_waits);
        if (wr) ref_mem[widx] = (ref_mem[widx] & ~lane_mask(exp_mask)) | (wd & lane_mask(exp_mask));
    endtask

    initial begin
        int d_at, i_at;
        logic ack_seen;
        nreset = 1'b0;
        imem_haddr = 32'd0; imem_hwrite = 1'b0; imem_hsize = 3'd2; imem_htrans = 2'b00; imem_hwdata = 32'd0;
        dmem_haddr = 32'd0; dmem_hwrite = 1'b0; dmem_hsize = 3'd2; dmem_htrans = 2'b00; dmem_hwdata = 32'd0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'd0;
        wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;

        // reset state
        #2;
        chk("rst_imem_hready", {31'd0, imem_hready}, 32'd1);
        chk("rst_dmem_hready", {31'd0, dmem_hready}, 32'd1);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
        chk("rst_hresp", {30'd0, imem_hresp, dmem_hresp}, 32'd0);
        cyc_start();
        cyc_start();
        nreset = 1'b1;

        // word write / read
        dmem_xfer("w_word", 1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 1, 4'b1111);
        dmem_xfer("r_word", 1'b0, 3'd2, 32'h0000_0010, 32'd0, 2, 4'b0000);

        // byte and half writes
        dmem_xfer("w_base", 1'b1, 3'd2, 32'h0000_0010, 32'h11223344, 1, 4'b1111);
        dmem_xfer("w_byte", 1'b1, 3'd0, 32'h0000_0013, 32'hAA000000, 1, 4'b1000);
        dmem_xfer("r_byte", 1'b0, 3'd2, 32'h0000_0010, 32'd0, 2, 4'b0000);
        chk("byte_ref", ref_mem[4], 32'hAA223344);
        dmem_xfer("w_half", 1'b1, 3'd1, 32'h0000_0012, 32'h55660000, 1, 4'b1100);
        dmem_xfer("r_half", 1'b0, 3'd2, 32'h0000_0010, 32'd0, 2, 4'b0000);

        // imem/dmem read collision: dmem completes first, imem one cycle later
        dmem_xfer("w_imemdat", 1'b1, 3'd2, 32'h0000_0020, 32'hCAFEF00D, 1, 4'b1111);
        cyc_start();
        dmem_haddr = 32'h0000_0010; dmem_hwrite = 1'b0; dmem_hsize = 3'd2; dmem_htrans = 2'b10;
        imem_haddr = 32'h0000_0020; imem_hwrite = 1'b0; imem_hsize = 3'd2; imem_htrans = 2'b10;
        sb_q.push_back(ref_mem[4]);
        sb_q.push_back(ref_mem[8]);
        settle();
        d_at = -1; i_at = -1;
        for (int k = 1; k < 10; k++) begin
            if (d_at < 0 || i_at < 0) begin
                cyc_start();
                dmem_htrans = 2'b00; imem_htrans = 2'b00;
                settle();
                if (dmem_hready && d_at < 0) begin d_at = k; sb_chk("col_dmem_rdata", dmem_hrdata); end
                if (imem_hready && i_at < 0) begin i_at = k; sb_chk("col_imem_rdata", imem_hrdata); end
            end
        end
        chk("col_dmem_cycle", d_at, 3);
        chk("col_imem_cycle", i_at, 4);

        // wb write collides with a dmem read and wins
        dmem_xfer("w_wbbase", 1'b1, 3'd2, 32'h0000_0100, 32'hA5A5A5A5, 1, 4'b1111);
        cyc_start();
        dmem_haddr = 32'h0000_0010; dmem_hwrite = 1'b0; dmem_htrans = 2'b10;
        sb_q.push_back(ref_mem[4]);
        cyc_start();
        dmem_htrans = 2'b00;
        cyc_start();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'b0011;
        wbs_adr_i = 32'h0000_0100; wbs_dat_i = 32'h0000BEEF;
        settle();
        chk("wb_gnt_we", {31'd0, sram_en & sram_we}, 32'd1);
        chk("wb_gnt_mask", {28'd0, sram_wmask}, 32'h3);
        chk("wb_gnt_addr", {21'd0, sram_addr}, 32'h40);
        chk("wb_ack_n", {31'd0, wbs_ack_o}, 32'd0);
        chk("wb_dmem_wait0", {31'd0, dmem_hready}, 32'd0);
        cyc_start();
        settle();
        chk("wb_ack_n1", {31'd0, wbs_ack_o}, 32'd1);
        chk("wb_dmem_wait1", {31'd0, dmem_hready}, 32'd0);
        chk("wb_dmem_gnt", {31'd0, sram_en & ~sram_we}, 32'd1);
        cyc_start();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        settle();
        chk("wb_ack_n2", {31'd0, wbs_ack_o}, 32'd0);
        chk("wb_dmem_done", {31'd0, dmem_hready}, 32'd1);
        sb_chk("wb_dmem_rdata", dmem_hrdata);
        ref_mem[32'h40] = (ref_mem[32'h40] & ~lane_mask(4'b0011)) | (32'h0000BEEF & lane_mask(4'b0011));

        // wb read of the partially written word
        cyc_start();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'b1111;
        wbs_adr_i = 32'h0000_0100;
        sb_q.push_back(ref_mem[32'h40]);
        settle();
        ack_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (!ack_seen) begin
                cyc_start();
                settle();
                if (wbs_ack_o) begin
                    ack_seen = 1'b1;
                    sb_chk("wb_rd_data", wbs_dat_o);
                end
            end
        end
        chk("wb_rd_ack", {31'd0, ack_seen}, 32'd1);
        cyc_start();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("wb_rd_ref", ref_mem[32'h40], 32'hA5A5BEEF);

        // address wrap modulo the SRAM size
        dmem_xfer("w_wrap", 1'b1, 3'd2, 32'h0000_2000, 32'h12345678, 1, 4'b1111);
        dmem_xfer("r_wrap", 1'b0, 3'd2, 32'h0000_0000, 32'd0, 2, 4'b0000);
        chk("wrap_ref", ref_mem[0], 32'h12345678);

        // reset while a dmem read is pending
        cyc_start();
        dmem_haddr = 32'h0000_0010; dmem_hwrite = 1'b0; dmem_htrans = 2'b10;
        cyc_start();
        dmem_htrans = 2'b00;
        settle();
        chk("mr_pending", {31'd0, dmem_hready}, 32'd0);
        nreset = 1'b0;
        #1;
        chk("mr_hready", {31'd0, dmem_hready}, 32'd1);
        chk("mr_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("mr_sram_en", {31'd0, sram_en}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc_start();
            settle();
            chk("mr_hold_en", {31'd0, sram_en}, 32'd0);
        end
        cyc_start();
        nreset = 1'b1;
        dmem_xfer("pr_w", 1'b1, 3'd2, 32'h0000_0030, 32'h0BADF00D, 1, 4'b1111);
        dmem_xfer("pr_r", 1'b0, 3'd2, 32'h0000_0030, 32'd0, 2, 4'b0000);

        chk("sb_empty", sb_q.size(), 32'd0);
        cyc_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/airi5c_mem_arbiter.md
Name: airi5c_mem_arbiter

Overview:
Shares one single-port 32-bit SRAM macro between three requesters:
- the core instruction AHB-lite (HASTI) port, imem
- the core data AHB-lite (HASTI) port, dmem
- the management Wishbone slave, wb, used for program load and debug peek/poke

Each AHB port gets an address-phase capture register and wait-state generation. Wishbone is converted to a single-ack access. The block sits between airi5c_top_asic and the SRAM inside the user project wrapper.

Parameters:
- ADDR_WIDTH, 11, SRAM word-address bits (2^11 words = 8 KiB)

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- imem_haddr / dmem_haddr  in  32  AHB address
- imem_hwrite / dmem_hwrite  in  1  AHB write
- imem_hsize / dmem_hsize  in  3  AHB size (0 byte, 1 half, 2 word)
- imem_htrans / dmem_htrans  in  2  AHB transfer type
- imem_hwdata / dmem_hwdata  in  32  AHB write data (data phase)
- imem_hrdata / dmem_hrdata  out  32  AHB read data
- imem_hready / dmem_hready  out  1  AHB ready
- imem_hresp / dmem_hresp  out  1  AHB response, constant 0 (OKAY)
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone control
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32  Wishbone address / write data
- wbs_ack_o  out  1  Wishbone ack
- wbs_dat_o  out  32  Wishbone read data
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write
- sram_wmask  out  4  SRAM byte write mask
- sram_addr  out  ADDR_WIDTH  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (nreset=0, asynchronous):
  - all pending flags cleared
  - imem_hready=dmem_hready=1, wbs_ack_o=0, sram_en=0
  - priority pointer set to dmem
- An access asserted mid-operation when reset arrives is dropped; no SRAM write is issued after reset assertion.
- AHB capture: in a cycle with hready=1 and htrans[1]=1 (NONSEQ/SEQ), latch haddr, hwrite and hsize, then set pending. IDLE/BUSY transfers are ignored and complete with zero wait.
- AHB data phase:
  - While pending and not yet completed, hready=0.
  - The master holds hwdata stable throughout.
- Grant: at most one grant per cycle to the SRAM port. Fixed priority wb > dmem > imem.
  - Only pending AHB entries are eligible; an entry cannot be granted in its own capture cycle.
  - wb is eligible when cyc&stb=1, no ack is pending, and ack is not being driven this cycle.
- AHB write granted in cycle N:
  - sram_en=sram_we=1, sram_wdata=hwdata.
  - hready=1 in cycle N (combinational) and pending clears.
  - Net latency: one wait state.
- AHB read granted in cycle N:
  - sram_en=1, sram_we=0.
  - In N+1, hready=1 and hrdata=sram_rdata, and pending clears. A new address phase may be captured in N+1.
  - Net latency: two wait states.
- wb granted in cycle N:
  - SRAM op with sram_wmask=wbs_sel_i on a write.
  - wbs_ack_o=1 for exactly one cycle, N+1. On a read, wbs_dat_o=sram_rdata in N+1.
- The SRAM port is pipelined: a new grant may issue in N+1 while a read from N returns.
- Byte mask (AHB) from hsize and haddr[1:0]:
  - byte: 0001 shifted left by addr[1:0]
  - half: 0011 shifted by {addr[1],0}
  - word: 1111
  - hsize > 2 is treated as word.
- Address: sram_addr = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo SRAM size. No error response.
- hrdata and wbs_dat_o are only valid in the completion cycle; otherwise undefined but stable.
- When idle, sram_en=0 and all SRAM outputs hold their previous values.
- Fixed priority can starve imem under continuous dmem/wb traffic; this is accepted in the default build.

Optional Feature:
- Macro AIRI5C_MEM_ARB_RR_EN.
- Defined:
  - imem and dmem arbitrate round-robin. A 1-bit pointer favours the port not granted last; it updates on every AHB grant.
  - wb keeps absolute priority.
- Undefined: fixed wb > dmem > imem, and no pointer register is present.

Test Plan:
- After reset, dmem word write 0xDEADBEEF to 0x0000_0010, then a read from the same address:
  - write: hready low 1 cycle
  - SRAM: sram_addr=4, wmask=1111
  - read: 2 wait states, then hrdata=0xDEADBEEF
- dmem byte write 0xAA at 0x13 (hsize=0) over 0x11223344:
  - wmask=1000
  - word read returns 0xAA223344
  - half write 0x5566 at 0x12 then gives wmask=1100
- imem and dmem reads captured in the same cycle:
  - default: dmem granted first, imem one cycle later; imem_hready rises 1 cycle after dmem_hready
  - with AIRI5C_MEM_ARB_RR_EN: a repeat of the same collision grants imem first
- wb write to 0x0000_0100 (sel=0011, data=0x0000BEEF) concurrent with a dmem read:
  - wb granted first; ack exactly 1 cycle
  - dmem completes one cycle later
  - wb read returns 0x????BEEF, with upper bytes unchanged
- Address wrap with ADDR_WIDTH=11:
  - write 0x12345678 to 0x0000_2000
  - read of 0x0000_0000 returns 0x12345678
- nreset asserted while a dmem read is pending:
  - hready=1, ack=0, sram_en=0 immediately
  - after release, next access behaves as after a clean reset
